// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single AXI3 master.
// One read and one write may be outstanding; data reads beat instruction reads.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} wstate_t;

  rstate_t     r_rstate, w_rnext;
  wstate_t     r_wstate, w_wnext;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awdone;
  logic        r_wdone;

  logic w_hazard;
  logic w_dr_acc;
  logic w_dw_acc;
  logic w_ir_acc;
  logic w_r_fire;
  logic w_rd_data;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;

  // A read of the word still being written must wait for the B response.
  assign w_hazard = (r_wstate != W_IDLE)
                 && (data_addr[31:2] == r_awaddr[31:2]);
  assign w_dr_acc = resetn && (r_rstate == R_IDLE)
                 && data_req && !data_wr && !w_hazard;
  assign w_dw_acc = resetn && (r_wstate == W_IDLE)
                 && data_req && data_wr;
  assign w_ir_acc = resetn && (r_rstate == R_IDLE)
                 && inst_req && !w_dr_acc && !w_dw_acc;

  assign arvalid   = (r_rstate == R_AR);
  assign rready    = (r_rstate == R_R);
  assign w_r_fire  = rready && rvalid;
  assign w_rd_data = w_r_fire && (rid == DATA_ID);
  assign awvalid   = (r_wstate == W_SEND) && !r_awdone;
  assign wvalid    = (r_wstate == W_SEND) && !r_wdone;
  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;
  // Hold off B while a data read returns so data_data_ok fires once per cycle.
  assign bready    = (r_wstate == W_B) && !w_rd_data;
  assign w_b_fire  = bvalid && bready;

  assign inst_addr_ok = w_ir_acc;
  assign data_addr_ok = w_dr_acc || w_dw_acc;
  assign inst_data_ok = w_r_fire && (rid != DATA_ID);
  assign data_data_ok = w_rd_data || w_b_fire;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = r_arsize;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = DATA_ID;
  assign awaddr  = r_awaddr;
  assign awsize  = r_awsize;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = DATA_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_dr_acc || w_ir_acc) w_rnext = R_AR;
      R_AR:    if (arready) w_rnext = R_R;
      R_R:     if (rvalid) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_dw_acc) w_wnext = W_SEND;
      W_SEND:  if ((r_awdone || w_aw_fire) && (r_wdone || w_w_fire))
                 w_wnext = W_B;
      W_B:     if (w_b_fire) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_arid   <= 4'd0;
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
    end else if (w_dr_acc) begin
      r_arid   <= DATA_ID;
      r_araddr <= data_addr;
      r_arsize <= {1'b0, data_size};
    end else if (w_ir_acc) begin
      r_arid   <= INST_ID;
      r_araddr <= inst_addr;
      r_arsize <= {1'b0, inst_size};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr <= 32'd0;
      r_awsize <= 3'd0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_awdone <= 1'b0;
      r_wdone  <= 1'b0;
    end else if (w_dw_acc) begin
      r_awaddr <= data_addr;
      r_awsize <= {1'b0, data_size};
      r_wdata  <= data_wdata;
      r_wstrb  <= data_wstrb;
      r_awdone <= 1'b0;
      r_wdone  <= 1'b0;
    end else if (r_wstate == W_SEND) begin
      if (w_aw_fire) r_awdone <= 1'b1;
      if (w_w_fire) r_wdone <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Random SRAM-side traffic against a random-latency AXI slave model;
// responses are scoreboarded against address-derived reference data.
module tb_sram_axi_bridge;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic clk = 1'b0;
  logic resetn;
  logic inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, rid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;
  logic arvalid, arready, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic [2:0]  sz;
  } wr_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] inst_q[$];
  logic [31:0] rd_q[$];
  wr_t wr_q[$];
  int w_acc_cnt = 0;
  int w_done_cnt = 0;
  logic [31:0] wpend_addr = 32'd0;
  bit hold_ar = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Slave read data is a fixed function of the AR address and size.
  function automatic logic [31:0] ref_rd(input logic [31:0] a,
                                         input logic [2:0] s);
    return (a * 32'h9E3779B1) ^ {s, 29'd0};
  endfunction

  // AXI slave with random ready and response latency.
  bit f_ar, f_r, f_aw, f_w, f_b;
  bit s_rq, s_aw, s_w, s_bq;
  int s_rdly, s_bdly;
  logic [3:0] s_id, s_wstrb;
  logic [31:0] s_addr, s_awaddr, s_wdata;
  logic [2:0] s_sz, s_awsz;
  wr_t e;

  initial begin
    arready = 0; rvalid = 0; rid = 0; rdata = 0;
    awready = 0; wready = 0; bvalid = 0;
    s_rq = 0; s_aw = 0; s_w = 0; s_bq = 0;
    forever begin
      @(negedge clk);
      f_ar = arvalid && arready;
      f_r = rvalid && rready;
      f_aw = awvalid && awready;
      f_w = wvalid && wready;
      f_b = bvalid && bready;
      if (f_ar) begin
        s_id = arid; s_addr = araddr; s_sz = arsize;
        s_rq = 1; s_rdly = int'($urandom % 4);
      end
      if (f_aw) begin s_aw = 1; s_awaddr = awaddr; s_awsz = awsize; end
      if (f_w) begin s_w = 1; s_wdata = wdata; s_wstrb = wstrb; end
      @(posedge clk);
      #1;
      if (!resetn) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        s_rq = 0; s_aw = 0; s_w = 0; s_bq = 0;
      end else begin
        if (f_r) rvalid = 0;
        if (f_b) bvalid = 0;
        if (s_rq && !rvalid) begin
          if (s_rdly == 0) begin
            rvalid = 1; rid = s_id; rdata = ref_rd(s_addr, s_sz); s_rq = 0;
          end else s_rdly--;
        end
        if (s_aw && s_w) begin
          if (wr_q.size() == 0) fail("write_unexpected");
          else begin
            e = wr_q.pop_front();
            chk("awaddr", s_awaddr, e.a);
            chk("wdata", s_wdata, e.d);
            chk("wstrb", 32'(s_wstrb), 32'(e.st));
            chk("awsize", 32'(s_awsz), 32'(e.sz));
          end
          s_aw = 0; s_w = 0; s_bq = 1; s_bdly = int'($urandom % 4);
        end
        if (s_bq && !bvalid) begin
          if (s_bdly == 0) begin bvalid = 1; s_bq = 0; end
          else s_bdly--;
        end
        arready = hold_ar ? 1'b0 : 1'($urandom % 2);
        awready = 1'($urandom % 2);
        wready = 1'($urandom % 2);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT signals completion.
  bit m_dfire;
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        m_dfire = rvalid && rready && (rid == DATA_ID);
        if (inst_addr_ok && data_addr_ok) fail("addr_ok_both_high");
        if (m_dfire && bvalid) chk("bready_on_collision", 32'(bready), 0);
        if (inst_data_ok) begin
          if (inst_q.size() == 0) fail("inst_data_ok_spurious");
          else chk("inst_rdata", inst_rdata, inst_q.pop_front());
        end
        if (data_data_ok) begin
          if (m_dfire) begin
            if (rd_q.size() == 0) fail("data_read_spurious");
            else chk("data_rdata", data_rdata, rd_q.pop_front());
          end else if (bvalid && bready) begin
            chk("write_resp_pending", 32'(w_acc_cnt - w_done_cnt), 1);
            w_done_cnt++;
          end else fail("data_data_ok_spurious");
        end else if (m_dfire) fail("data_read_not_signalled");
      end
    end
  end

  task automatic inst_proc(input int cyc);
    bit acc = 0;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      if (acc) begin inst_req = 0; acc = 0; end
      if (!inst_req && ($urandom % 3) == 0) begin
        inst_req = 1; inst_addr = $urandom; inst_size = 2'($urandom % 3);
      end
      @(negedge clk);
      if (inst_req && inst_addr_ok) begin
        inst_q.push_back(ref_rd(inst_addr, {1'b0, inst_size}));
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    inst_req = 0;
  endtask

  task automatic data_proc(input int cyc);
    bit acc = 0;
    wr_t w;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      if (acc) begin data_req = 0; acc = 0; end
      if (!data_req && ($urandom % 2) == 0) begin
        data_req = 1;
        data_wr = 1'($urandom % 2);
        data_addr = (($urandom % 4 == 0) ? 32'h200 : 32'h100)
                  + (($urandom % 4) << 2) + (data_wr ? 0 : $urandom % 4);
        data_size = 2'($urandom % 3);
        data_wdata = $urandom;
        data_wstrb = 4'($urandom);
      end
      @(negedge clk);
      if (data_req && !data_wr && (w_acc_cnt != w_done_cnt)
          && data_addr[31:2] == wpend_addr[31:2])
        chk("raw_hazard_block", 32'(data_addr_ok), 0);
      if (data_req && data_addr_ok) begin
        if (data_wr) begin
          w.a = data_addr; w.d = data_wdata;
          w.st = data_wstrb; w.sz = {1'b0, data_size};
          wr_q.push_back(w);
          wpend_addr = data_addr;
          w_acc_cnt++;
        end else rd_q.push_back(ref_rd(data_addr, {1'b0, data_size}));
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    data_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int spur;
    resetn = 0;
    inst_req = 1; inst_size = 2; inst_addr = 32'h1C000000;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1000;
    data_wdata = 0; data_wstrb = 0;
    repeat (3) @(negedge clk);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("axi_const", {arlen, awlen, arburst, awburst, arlock, awlock,
                      arcache, awcache}, {8'd0, 4'b0101, 4'd0, 8'd0});
    chk("axi_const2", {arprot, awprot, wid, wlast}, {6'd0, DATA_ID, 1'b1});
    inst_req = 0; data_req = 0;
    @(posedge clk);
    #1;
    resetn = 1;

    fork
      inst_proc(3000);
      data_proc(3000);
    join

    t = 0;
    while ((inst_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0
            || w_acc_cnt != w_done_cnt) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail("drain_timeout");
    repeat (2) @(posedge clk);

    hold_ar = 1;
    @(posedge clk);
    #1;
    inst_req = 1; inst_addr = 32'h1C000000; inst_size = 2;
    @(negedge clk);
    chk("mid_rst_inst_addr_ok", 32'(inst_addr_ok), 1);
    @(posedge clk);
    #1;
    inst_req = 0;
    @(negedge clk);
    chk("mid_rst_arvalid_before", 32'(arvalid), 1);
    chk("mid_rst_araddr", araddr, 32'h1C000000);
    chk("mid_rst_arid", 32'(arid), 32'(INST_ID));
    #2;
    resetn = 0;
    #1;
    chk("mid_rst_arvalid_drop", 32'(arvalid), 0);
    chk("mid_rst_araddr_clr", araddr, 0);
    inst_q.delete(); rd_q.delete(); wr_q.delete();
    w_done_cnt = w_acc_cnt;
    repeat (3) @(posedge clk);
    #1;
    hold_ar = 0;
    resetn = 1;
    spur = 0;
    repeat (20) begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok || arvalid) spur++;
    end
    chk("post_rst_no_activity", 32'(spur), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter INST_ID, default 4'd0: ARID used for instruction reads.
REQ-002 Parameter DATA_ID, default 4'd1: ARID/AWID used for data accesses.
REQ-003 The bridge SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 inst_req/inst_size/inst_addr  in  1/2/32  instruction read request (read-only port).
REQ-007 inst_addr_ok/inst_data_ok  out  1/1  request accepted / read data valid.
REQ-008 inst_rdata  out  32  instruction read data.
REQ-009 data_req/data_wr/data_size/data_wstrb  in  1/1/2/4  data request, write flag, size, byte strobes.
REQ-010 data_addr/data_wdata  in  32/32  data address / write data.
REQ-011 data_addr_ok/data_data_ok  out  1/1  request accepted / read data or write response done.
REQ-012 data_rdata  out  32  data read data.
REQ-013 arid/araddr/arsize/arvalid  out  4/32/3/1  and arready in 1: AXI read address channel.
REQ-014 rid/rdata/rvalid  in  4/32/1  and rready out 1: AXI read data channel; rresp/rlast ignored.
REQ-015 awid/awaddr/awsize/awvalid  out  4/32/3/1  and awready in 1: AXI write address channel.
REQ-016 wdata/wstrb/wvalid  out  32/4/1  and wready in 1: AXI write data channel.
REQ-017 bvalid  in  1  and bready out 1: AXI write response channel.
REQ-018 arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wid=DATA_ID, wlast=1: constant outputs.

Function
REQ-019 Handshake: a request is accepted in the cycle req && addr_ok; a transfer completes in the cycle valid && ready.
REQ-020 Read FSM states: R_IDLE, R_AR, R_R; at most one read outstanding.
REQ-021 R_IDLE: if data_req && !data_wr and not blocked (REQ-029), assert data_addr_ok combinationally and go to R_AR; else if inst_req, assert inst_addr_ok and go to R_AR.
REQ-022 Data read SHALL have priority over instruction read when both request in the same cycle.
REQ-023 On acceptance: latch araddr=addr, arsize={1'b0,size}, arid=INST_ID/DATA_ID; arvalid=1 from the next cycle.
REQ-024 R_AR: hold arvalid and all AR fields stable until arready; then arvalid=0 and go to R_R.
REQ-025 R_R: rready=1; on rvalid, route by rid: rid==DATA_ID pulses data_data_ok with data_rdata=rdata; otherwise pulses inst_data_ok with inst_rdata=rdata; same cycle as rvalid; return to R_IDLE.
REQ-026 Write FSM states: W_IDLE, W_SEND, W_B; at most one write outstanding.
REQ-027 W_IDLE: if data_req && data_wr and no data read is accepted that cycle, assert data_addr_ok, latch addr/wdata/wstrb/size, go to W_SEND.
REQ-028 W_SEND: awvalid and wvalid asserted independently; each deasserts after its own handshake; AW and W may complete in either order or together; go to W_B once both are done.
REQ-029 A data read SHALL be blocked (no data_addr_ok) while the write FSM is not W_IDLE and data_addr[31:2]==latched awaddr[31:2].
REQ-030 W_B: bready=1 except in cycles where the read FSM completes a DATA_ID read (rvalid && rready && rid==DATA_ID), so data_data_ok never fires twice in one cycle; on bvalid && bready, pulse data_data_ok and go to W_IDLE.
REQ-031 data_addr_ok and inst_addr_ok SHALL never be high in the same cycle.
REQ-032 data_data_ok/inst_data_ok are single-cycle pulses; rdata outputs need only be valid while the pulse is high.

Reset
REQ-033 While resetn=0: both FSMs idle; arvalid, awvalid, wvalid, rready, bready, all addr_ok and data_ok = 0; latched address/data registers = 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no data_ok issued after release.

Verification
REQ-035 inst_req at 0x1C000000 with arready=1 and rvalid=1 (rid=0, rdata=0x02800000) two cycles later -> inst_addr_ok high on cycle 0, arvalid on cycle 1, inst_data_ok and inst_rdata=0x02800000 on the rvalid cycle.
REQ-036 inst_req and data read at 0x00001000 in the same cycle -> data_addr_ok=1, inst_addr_ok=0, araddr=0x00001000, arid=1; inst accepted only after the data read completes.
REQ-037 Data write 0x8000_0010, wdata=0x12345678, wstrb=4'b0011, wready two cycles after awready -> awvalid drops first, wvalid later, then data_data_ok on bvalid.
REQ-038 Data write to 0x100 outstanding, then data read of 0x102 -> no data_addr_ok until the B handshake; a read of 0x200 is accepted at once.
REQ-039 DATA_ID rvalid and bvalid in the same cycle -> bready=0 that cycle; data_data_ok pulses twice on consecutive cycles, read first.
REQ-040 resetn pulled low while in R_AR with arvalid=1 -> arvalid=0 immediately; after release, no inst_data_ok or data_data_ok occurs without a new request.
